// File: rtl/spi_slave.sv
// spi_slave: SPI target; oversampled SCK/SSn/MOSI, valid/ready RX and TX words, CPOL/CPHA modes; LSB-first option under SPI_SLAVE_LSB_FIRST_EN.
// miso moves 3 clk after a SCK shift edge, rx_valid rises 4 clk after the last sample edge; RX cannot stall the master (overrun drops the word).
module spi_slave #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE    = 8'hFF
) (
`ifdef SPI_SLAVE_LSB_FIRST_EN
  input  logic                  lsb_first,
`endif
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sck,
  input  logic                  ssn,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  rx_overrun,
  output logic                  tx_underrun,
  output logic                  frame_abort
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state;
  logic                  sck_s1, sck_s2, sck_h;
  logic                  ssn_s1, ssn_s2, ssn_h;
  logic                  mosi_s1, mosi_s2;
  logic [1:0]            prime;
  logic                  armed;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] rx_sr, tx_sr;
  logic                  lsb;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign lsb = lsb_first;
`else
  assign lsb = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s1  <= cpol;
      sck_s2  <= cpol;
      sck_h   <= cpol;
      ssn_s1  <= 1'b1;
      ssn_s2  <= 1'b1;
      ssn_h   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      prime   <= 2'b00;
      armed   <= 1'b0;
    end else begin
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_h   <= sck_s2;
      ssn_s1  <= ssn;
      ssn_s2  <= ssn_s1;
      ssn_h   <= ssn_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      prime   <= {prime[0], 1'b1};
      // The reset value of the ssn chain is not a real sample; a frame needs a genuinely observed high first.
      if (prime[1] && ssn_s2)
        armed <= 1'b1;
    end
  end

  logic                  sck_edge, lead, trail, sample_edge, shift_edge;
  logic                  ssn_fall, ssn_rise, accept, word_done;
  logic [DATA_WIDTH-1:0] next_word, rx_shifted;

  assign sck_edge    = sck_s2 ^ sck_h;
  assign lead        = sck_edge & (sck_s2 ^ cpol);
  assign trail       = sck_edge & ~(sck_s2 ^ cpol);
  assign sample_edge = cpha ? trail : lead;
  assign shift_edge  = cpha ? lead : trail;
  assign ssn_fall    = armed & ssn_h & ~ssn_s2;
  assign ssn_rise    = ssn_s2 & ~ssn_h;
  assign accept      = rx_valid & rx_ready;
  assign word_done   = (cnt == CW'(DATA_WIDTH));
  assign next_word   = tx_valid ? tx_data : TX_IDLE;
  assign rx_shifted  = lsb ? {mosi_s2, rx_sr[DATA_WIDTH-1:1]}
                           : {rx_sr[DATA_WIDTH-2:0], mosi_s2};

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic l);
    return l ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] drop_bit(input logic [DATA_WIDTH-1:0] w, input logic l);
    return l ? (w >> 1) : (w << 1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      tx_ready    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      cnt         <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
    end else begin
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_abort <= 1'b0;

      if (accept)
        rx_valid <= 1'b0;

      // Completion and acceptance in the same cycle is a clean hand-over, not an overrun.
      if (state == ACTIVE && word_done) begin
        if (!rx_valid || accept) begin
          rx_data  <= rx_sr;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (ssn_fall) begin
            state       <= ACTIVE;
            busy        <= 1'b1;
            miso_oe     <= 1'b1;
            cnt         <= '0;
            rx_sr       <= '0;
            tx_ready    <= tx_valid;
            tx_underrun <= ~tx_valid;
            // cpha=0 has no leading shift edge before the first sample, so the first bit goes out now.
            if (cpha) begin
              tx_sr <= next_word;
            end else begin
              miso  <= first_bit(next_word, lsb);
              tx_sr <= drop_bit(next_word, lsb);
            end
          end
        end

        ACTIVE: begin
          if (ssn_rise) begin
            state       <= IDLE;
            busy        <= 1'b0;
            miso_oe     <= 1'b0;
            miso        <= 1'b0;
            frame_abort <= (cnt != '0) && !word_done;
            cnt         <= '0;
          end else if (word_done) begin
            cnt         <= '0;
            tx_sr       <= next_word;
            tx_ready    <= tx_valid;
            tx_underrun <= ~tx_valid;
          end else if (sample_edge) begin
            rx_sr <= rx_shifted;
            cnt   <= cnt + CW'(1);
          end else if (shift_edge) begin
            miso  <= first_bit(tx_sr, lsb);
            tx_sr <= drop_bit(tx_sr, lsb);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master at clk/8 against hand-computed words in all four modes.
module tb_spi_slave;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset, cpol, cpha, sck, ssn, mosi;
  logic       miso, miso_oe, tx_ready, rx_valid, rx_ready, tx_valid;
  logic       busy, rx_overrun, tx_underrun, frame_abort;
  logic [7:0] tx_data, rx_data;

  int checks = 0;
  int errors = 0;
  int n_txr = 0, n_un = 0, n_ovr = 0, n_abt = 0;
  int snap_txr = 0, snap_un = 0;
  logic [7:0] rxq[$];

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .sck(sck), .ssn(ssn),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .frame_abort(frame_abort)
  );

  always @(negedge clk) begin
    if (rx_valid && rx_ready) rxq.push_back(rx_data);
    if (tx_ready)    n_txr++;
    if (tx_underrun) n_un++;
    if (rx_overrun)  n_ovr++;
    if (frame_abort) n_abt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    sck  = pol;
    #(4 * HALF);
  endtask

  task automatic frame_start();
    ssn = 1'b0;
    #(2 * HALF);
  endtask

  task automatic frame_end();
    #(HALF);
    ssn = 1'b1;
    #(4 * HALF);
  endtask

  // Master side: drives mosi and samples miso on the edges the mode dictates.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) mosi = mo[i];
      #(HALF);
      sck = ~cpol;
      if (cpha) mosi = mo[i];
      else r[i] = miso;
      if (!cpha && i == 8 - nbits) begin snap_txr = n_txr; snap_un = n_un; end
      #(HALF);
      sck = cpol;
      if (cpha) begin
        r[i] = miso;
        if (i == 8 - nbits) begin snap_txr = n_txr; snap_un = n_un; end
      end
    end
    mi = r;
  endtask

  task automatic expect_rx(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    for (int k = 0; k < 200 && rxq.size() == 0; k++) @(negedge clk);
    got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
    check(tag, {24'h0, got}, {24'h0, exp});
  endtask

  task automatic mode_xfer(input string tag, input logic pol, input logic pha,
                           input logic [7:0] txw, input logic [7:0] mow);
    logic [7:0] mi;
    int base;
    set_mode(pol, pha);
    tx_data  = txw;
    tx_valid = 1'b1;
    base     = n_txr;
    frame_start();
    check({tag, "_busy"}, {31'h0, busy}, 32'h1);
    xfer(mow, 8, mi);
    frame_end();
    check({tag, "_miso_word"}, {24'h0, mi}, {24'h0, txw});
    check({tag, "_tx_ready_cnt"}, snap_txr - base, 1);
    expect_rx({tag, "_rx_word"}, mow);
    check({tag, "_oe_off"}, {31'h0, miso_oe}, 32'h0);
  endtask

  initial begin
    logic [7:0] mi;
    int base_un, base_ovr, base_abt;

    reset = 1'b1; cpol = 1'b0; cpha = 1'b0; sck = 1'b0; ssn = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("rst_miso",     {31'h0, miso},        32'h0);
    check("rst_miso_oe",  {31'h0, miso_oe},     32'h0);
    check("rst_tx_ready", {31'h0, tx_ready},    32'h0);
    check("rst_rx_data",  {24'h0, rx_data},     32'h0);
    check("rst_rx_valid", {31'h0, rx_valid},    32'h0);
    check("rst_busy",     {31'h0, busy},        32'h0);
    check("rst_pulses",   {29'h0, rx_overrun, tx_underrun, frame_abort}, 32'h0);

    mode_xfer("m0", 1'b0, 1'b0, 8'hA5, 8'h3C);
    mode_xfer("m1", 1'b0, 1'b1, 8'h96, 8'h5A);
    mode_xfer("m2", 1'b1, 1'b0, 8'h96, 8'h5A);
    mode_xfer("m3", 1'b1, 1'b1, 8'h96, 8'h5A);

    // Three words in one frame with nothing to send: idle pattern out, three underruns.
    set_mode(1'b0, 1'b0);
    tx_valid = 1'b0;
    base_un  = n_un;
    base_abt = n_abt;
    rxq.delete();
    frame_start();
    xfer(8'h01, 8, mi); check("b2b_miso0", {24'h0, mi}, 32'hFF);
    xfer(8'h02, 8, mi); check("b2b_miso1", {24'h0, mi}, 32'hFF);
    xfer(8'h03, 8, mi); check("b2b_miso2", {24'h0, mi}, 32'hFF);
    check("b2b_underruns", snap_un - base_un, 3);
    frame_end();
    expect_rx("b2b_rx0", 8'h01);
    expect_rx("b2b_rx1", 8'h02);
    expect_rx("b2b_rx2", 8'h03);
    check("b2b_no_abort", n_abt - base_abt, 0);

    // Overrun: consumer stalled, second word is dropped.
    rx_ready = 1'b0;
    base_ovr = n_ovr;
    frame_start();
    xfer(8'h11, 8, mi);
    xfer(8'h22, 8, mi);
    frame_end();
    check("ovr_rx_valid", {31'h0, rx_valid}, 32'h1);
    check("ovr_rx_data",  {24'h0, rx_data},  32'h11);
    check("ovr_pulses",   n_ovr - base_ovr, 1);
    rx_ready = 1'b1;
    expect_rx("ovr_drain", 8'h11);
    repeat (3) @(negedge clk);
    check("ovr_drained", {31'h0, rx_valid}, 32'h0);

    // Abort after five bits, then a full word must still land correctly.
    base_abt = n_abt;
    rxq.delete();
    frame_start();
    xfer(8'hE4, 5, mi);
    frame_end();
    check("abt_pulse",    n_abt - base_abt, 1);
    check("abt_no_rx",    rxq.size(), 0);
    check("abt_rx_valid", {31'h0, rx_valid}, 32'h0);
    frame_start();
    xfer(8'h77, 8, mi);
    frame_end();
    expect_rx("abt_next_rx", 8'h77);

    // Reset mid-frame with ssn still low: no new frame until ssn toggles.
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    frame_start();
    xfer(8'hC3, 3, mi);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    check("mrst_miso_oe",  {31'h0, miso_oe},  32'h0);
    check("mrst_busy",     {31'h0, busy},     32'h0);
    check("mrst_rx_data",  {24'h0, rx_data},  32'h0);
    check("mrst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("mrst_miso",     {31'h0, miso},     32'h0);
    repeat (12) @(posedge clk);
    #2;
    check("mrst_no_frame", {31'h0, busy}, 32'h0);
    ssn = 1'b1;
    #(4 * HALF);
    rxq.delete();
    frame_start();
    xfer(8'hC3, 8, mi);
    frame_end();
    check("mrst_miso_word", {24'h0, mi}, 32'h5A);
    expect_rx("mrst_rx_word", 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
